// File: rtl/mc_pkg.sv
// mc_pkg: FSM states and op encodings shared by the multicycle front end and controller
package mc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_t;
  function automatic op_t start_op(input logic f, input logic l, input logic s);
    return f ? OP_FETCH : l ? OP_LOAD : s ? OP_STORE : OP_NONE;
  endfunction
  function automatic state_t op_state(input op_t op);
    return op == OP_FETCH ? FETCH : op == OP_LOAD ? LOAD : op == OP_STORE ? STORE : IDLE;
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: wait-state counter; expired flags the edge that would reach TIMEOUT_CYCLES
module mc_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 1'b1;
  end
  assign expired = (TIMEOUT_CYCLES > 0) && inc && (count == LAST);
endmodule

// File: rtl/mc_fetch_mem_unit.sv
// mc_fetch_mem_unit: PC/IR/MDR owner driving one shared req/ready memory port with timeout
module mc_fetch_mem_unit
  import mc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              load_start,
  input  logic              store_start,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              branch_out,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, state_d;
  op_t op;
  logic accept, complete, abort, expired;
  assign op = start_op(fetch_start, load_start, store_start);
  assign busy = state != IDLE;
  assign accept = (state == IDLE) && (op != OP_NONE);
  always_comb begin
    state_d = state;
    complete = 1'b0;
    abort = 1'b0;
    if (state == IDLE) state_d = op_state(op);
    else if (mem_ready) begin
      complete = 1'b1;
      state_d = IDLE;
    end else if (expired) begin
      abort = 1'b1;
      state_d = IDLE;
    end
  end
  mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .inc(busy && !mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  // PC writes are decoupled from the FSM so branches can resolve during a fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= PC_RESET;
    else if (pc_write || (pc_write_cond && branch_out)) pc <= pc_next;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= complete;
      err <= abort;
      if (accept) begin
        mem_req <= 1'b1;
        mem_we <= op == OP_STORE;
        mem_addr <= op == OP_FETCH ? pc : alu_out;
        if (op == OP_STORE) mem_wdata <= store_data;
      end else if (complete || abort) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= '0;
      mdr <= '0;
    end else if (complete) begin
      if (state == FETCH) instr <= mem_rdata;
      if (state == LOAD) mdr <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
// tb_mc_fetch_mem_unit: randomized self-checking bench against a transaction-level model
module tb_mc_fetch_mem_unit;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetch_start = 1'b0, load_start = 1'b0, store_start = 1'b0;
  logic [31:0] alu_out = '0, store_data = '0, pc_next = '0, mem_rdata = '0;
  logic pc_write = 1'b0, pc_write_cond = 1'b0, branch_out = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
  logic [31:0] m_pc, m_instr, m_mdr, m_wdata;
  int errors = 0;
  int checks = 0;

  mc_fetch_mem_unit #(.ADDR_W(32), .DATA_W(32), .PC_RESET(32'h0), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .fetch_start(fetch_start), .load_start(load_start), .store_start(store_start),
    .alu_out(alu_out), .store_data(store_data),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_out(branch_out), .pc_next(pc_next),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .mdr(mdr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = 32'h0;
    m_instr = '0;
    m_mdr = '0;
    m_wdata = '0;
  endfunction

  // op: 0 fetch, 1 load, 2 store; r: edge (1-based after accept) where ready is given, 0 = never
  task automatic do_txn(input int op, input logic [31:0] addr, input logic [31:0] wd, input int r,
                        input logic [31:0] rd, input logic ign, input logic pcw, input logic pcc,
                        input logic br, input logic [31:0] pcn);
    logic [31:0] exp_addr;
    logic [68:0] got, exp;
    logic [100:0] got2, exp2;
    logic ok, ab;
    exp_addr = (op == 0) ? m_pc : addr;
    if (op == 2) m_wdata = wd;
    fetch_start = op == 0;
    load_start = op == 1;
    store_start = op == 2;
    alu_out = addr;
    store_data = wd;
    @(negedge clk);
    fetch_start = 1'b0;
    load_start = 1'b0;
    store_start = 1'b0;
    alu_out = $urandom;
    store_data = $urandom;
    got = {mem_req, mem_we, mem_addr, mem_wdata, busy, done, err};
    exp = {1'b1, op == 2, exp_addr, m_wdata, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL accept op%0d: got %h expected %h", op, got, exp);
    end
    for (int c = 1; c <= T; c++) begin
      mem_ready = (c == r);
      mem_rdata = (c == r) ? rd : $urandom;
      if (c == 1) begin
        pc_write = pcw;
        pc_write_cond = pcc;
        branch_out = br;
        pc_next = pcn;
        fetch_start = ign;
        load_start = ign;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      branch_out = 1'b0;
      fetch_start = 1'b0;
      load_start = 1'b0;
      if (c == 1 && (pcw || (pcc && br))) m_pc = pcn;
      ok = (c == r);
      ab = (c == T) && !ok;
      if (ok || ab) begin
        if (ok && op == 0) m_instr = rd;
        if (ok && op == 1) m_mdr = rd;
        got2 = {mem_req, mem_we, busy, done, err, instr, mdr, pc};
        exp2 = {1'b0, 1'b0, 1'b0, ok, ab, m_instr, m_mdr, m_pc};
        checks++;
        if (got2 !== exp2) begin
          errors++;
          $display("FAIL finish op%0d edge %0d: got %h expected %h", op, c, got2, exp2);
        end
        break;
      end
      got = {mem_req, mem_we, mem_addr, mem_wdata, busy, done, err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wait op%0d edge %0d: got %h expected %h", op, c, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [199:0] got;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got = {pc, instr, mdr, mem_addr, mem_wdata, mem_req, mem_we, done, err, busy};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
  endtask

  task automatic test_async_reset_mid_fetch();
    logic [3:0] got;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    got = {mem_req, busy, done, err};
    checks++;
    if (got !== 4'b0 || pc !== 32'h0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got req/busy/done/err %b pc %h addr %h expected 0", got, pc, mem_addr);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_zero_wait();
    pc_write = 1'b1;
    pc_next = 32'h40;
    @(negedge clk);
    pc_write = 1'b0;
    m_pc = 32'h40;
    do_txn(0, 32'h0, 32'h0, 1, 32'h8C220004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done %b err %b expected 0 0", done, err);
    end
  endtask

  task automatic test_load_wait();
    do_txn(1, 32'h100, 32'h0, 4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_store_ignore();
    do_txn(2, 32'h200, 32'h12345678, 3, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_ignored_strobes: got busy %b req %b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_timeout();
    do_txn(0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err %b done %b expected 0 0", err, done);
    end
    do_txn(1, 32'h300, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_txn(1, 32'h304, 32'h0, T, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    logic [31:0] old;
    old = m_pc;
    pc_write_cond = 1'b1;
    branch_out = 1'b0;
    pc_next = 32'h80;
    @(negedge clk);
    pc_write_cond = 1'b0;
    checks++;
    if (pc !== old) begin
      errors++;
      $display("FAIL branch_not_taken: got %h expected %h", pc, old);
    end
    do_txn(0, 32'h0, 32'h0, 3, 32'h01234567, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    checks++;
    if (pc !== 32'h80) begin
      errors++;
      $display("FAIL branch_taken: got %h expected %h", pc, 32'h80);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(2, 32'h400, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_txn(1, 32'h400, 32'h0, 2, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_txn(0, 32'h0, 32'h0, 1, 32'h13579BDF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_txn($urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, T + 4), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle %0d: got done %b err %b busy %b expected 0 0 0", i, done, err, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset_mid_fetch();
    test_fetch_zero_wait();
    test_load_wait();
    test_store_ignore();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_fetch_mem_unit.md
Name: mc_fetch_mem_unit

Overview:
Parametrised successor to the multicycle CPU front end. Owns the PC, instruction register (IR) and memory data register (MDR), and drives one shared memory port with a req/ready handshake. That port supports variable wait states and a bus timeout. Sits between the multicycle controller (start strobes, PC write controls) and a unified instruction/data memory.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, memory word, IR and MDR width
PC_RESET, 0, PC value on reset
TIMEOUT_CYCLES, 16, max wait cycles before abort; 0 disables timeout

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
fetch_start  in  1  controller request: fetch instruction at pc
load_start  in  1  controller request: read word at alu_out into MDR
store_start  in  1  controller request: write store_data to alu_out
alu_out  in  ADDR_W  data access address
store_data  in  DATA_W  store write data (B register)
pc_write  in  1  unconditional PC write
pc_write_cond  in  1  conditional PC write (branch)
branch_out  in  1  branch condition from ALU
pc_next  in  ADDR_W  next PC value from PC source mux
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, valid while mem_req
mem_addr  out  ADDR_W  registered request address
mem_wdata  out  DATA_W  registered write data
mem_ready  in  1  memory accepts/completes the current request
mem_rdata  in  DATA_W  read data, valid when mem_ready
pc  out  ADDR_W  program counter
instr  out  DATA_W  instruction register
mdr  out  DATA_W  memory data register
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after a successful transaction
err  out  1  one-cycle pulse after a timeout abort

Behaviour:
- Reset (reset = 0, async): pc = PC_RESET; instr = 0; mdr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; done = 0; err = 0; state = IDLE; timer = 0. Outputs drop immediately, not at the next edge. A transaction in flight is discarded.
- PC update is independent of the FSM: pc_en = pc_write | (pc_write_cond & branch_out); pc <= pc_next when pc_en. It is legal while busy.
- FSM states: IDLE, FETCH, LOAD, STORE.
- IDLE:
  - Start strobes are sampled only in IDLE; strobes seen while busy are ignored.
  - Priority: fetch > load > store.
  - On accept, at the same edge: mem_req <= 1; mem_addr <= pc for fetch, else alu_out; mem_we <= 1 only for store; mem_wdata <= store_data for store; timer <= 0.
  - State moves to FETCH, LOAD or STORE. The address is captured at this edge, so a later PC change does not affect the request.
- FETCH/LOAD/STORE, at an edge where mem_ready = 1:
  - Completion: instr <= mem_rdata (FETCH) or mdr <= mem_rdata (LOAD); STORE loads neither.
  - mem_req <= 0, mem_we <= 0, done <= 1 for one cycle, state <= IDLE.
  - Minimum latency: start edge → mem_req high; ready seen at the next edge → done high the following cycle.
- Zero-wait memory: ready may be high in the first cycle mem_req is high; the transaction completes at that edge.
- Wait states: mem_addr, mem_we and mem_wdata stay stable and mem_req stays high until completion or abort.
- Timeout (TIMEOUT_CYCLES > 0):
  - Timer increments at each busy edge with mem_ready = 0.
  - At the edge where the timer would reach TIMEOUT_CYCLES: mem_req <= 0, mem_we <= 0, err <= 1 for one cycle, state <= IDLE.
  - instr and mdr are unchanged.
  - If mem_ready = 1 on that same edge, completion wins and there is no err.
- done and err are never high together.
- A new start may be accepted in the cycle done or err is high, since the FSM is in IDLE.
- mem_rdata is ignored whenever mem_req is low.

Decomposition:
- Shared package mc_pkg: state enum (IDLE, FETCH, LOAD, STORE) and op encoding constants reused by the controller.
- One sub-module: mc_wait_timer, a parametrised counter with clear, inc and expired (disabled when TIMEOUT_CYCLES = 0).
- PC, IR and MDR registers and the FSM stay in the top.

Test Plan:
- Reset release → pc = 0x00000000, instr = 0, mdr = 0, mem_req = 0. Assert reset mid-FETCH with ready held low → mem_req drops asynchronously and state = IDLE.
- pc = 0x40, fetch_start, zero-wait memory returning 0x8C220004 → mem_addr = 0x40 while mem_req; instr = 0x8C220004; done pulses one cycle; mdr unchanged.
- load_start, alu_out = 0x100, ready after 3 wait cycles, rdata = 0xDEADBEEF → mem_req high 4 cycles; mdr = 0xDEADBEEF; busy high throughout.
- store_start, alu_out = 0x200, store_data = 0x12345678 → mem_we = 1, mem_wdata = 0x12345678 stable until ready. fetch_start and load_start pulsed during wait → ignored.
- TIMEOUT_CYCLES = 16, ready never asserted → err pulses exactly once, 16 edges after the start edge; instr/mdr unchanged. Repeat with ready on edge 16 → done, no err.
- pc_write_cond = 1, branch_out = 0, pc_next = 0x80 → pc unchanged. branch_out = 1 → pc = 0x80 even while busy in FETCH; the in-flight mem_addr stays at the old pc.
